// File: rtl/fetch_iss_pipe.sv
// Fetch stage and FETCH->ISSUE pipeline register. It owns the PC, runs the imem
// request handshake, parks a response that lands during a stall, and injects NOPs on flush/bubble.
module fetch_iss_pipe #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_fetch_hz_i,
  input  logic        stall_iss_hz_i,
  input  logic        flush_iss_hz_i,
  input  logic        branch_taken_ex_mem_hz_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_iss_ex_hz_i,
  input  logic [31:0] jump_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rdy_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] pc_fetch_o,
  output logic [31:0] instr_iss_o,
  output logic [31:0] pc_plus4_iss_o,
  output logic        valid_iss_o
);

  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_HOLD, S_DRAIN} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_pc4_q, hold_pc4_d;

  logic        redirect;
  logic [31:0] redirect_target;
  logic        fetch_hold;
  logic [31:0] pc_plus4;
  logic        deliver;
  logic [31:0] dlv_instr;
  logic [31:0] dlv_pc4;

  // A taken branch is older than a jump in ISSUE, so it wins.
  assign redirect        = branch_taken_ex_mem_hz_i | jump_iss_ex_hz_i;
  assign redirect_target = branch_taken_ex_mem_hz_i ? branch_target_i : jump_target_i;
  // A stalled ISSUE register cannot accept, so it blocks hand-off like a fetch stall.
  assign fetch_hold      = stall_fetch_hz_i | stall_iss_hz_i;
  assign pc_plus4        = pc_q + 32'd4;

  assign imem_req_o  = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign imem_addr_o = pc_q;
  assign pc_fetch_o  = pc_q;

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latches).
    state_d      = state_q;
    pc_d         = pc_q;
    pend_d       = pend_q;
    hold_instr_d = hold_instr_q;
    hold_pc4_d   = hold_pc4_q;
    deliver      = 1'b0;
    dlv_instr    = imem_data_i;
    dlv_pc4      = pc_plus4;

    case (state_q)
      S_BOOT: begin
        state_d = S_FETCH;
        if (redirect) pc_d = redirect_target;
      end
      S_FETCH: begin
        if (redirect) begin
          // An unanswered request must stay up; remember the target and drain it.
          if (imem_rdy_i) begin
            pc_d = redirect_target;
          end else begin
            pend_d  = redirect_target;
            state_d = S_DRAIN;
          end
        end else if (imem_rdy_i && !flush_iss_hz_i) begin
          if (fetch_hold) begin
            hold_instr_d = imem_data_i;
            hold_pc4_d   = pc_plus4;
            state_d      = S_HOLD;
          end else begin
            deliver = 1'b1;
            pc_d    = pc_plus4;
          end
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pc_d    = redirect_target;
          state_d = S_FETCH;
        end else if (!fetch_hold && !flush_iss_hz_i) begin
          deliver   = 1'b1;
          dlv_instr = hold_instr_q;
          dlv_pc4   = hold_pc4_q;
          pc_d      = pc_plus4;
          state_d   = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (redirect) begin
          if (imem_rdy_i) begin
            pc_d    = redirect_target;
            state_d = S_FETCH;
          end else begin
            pend_d = redirect_target;
          end
        end else if (imem_rdy_i) begin
          pc_d    = pend_q;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // NOTE: hold buffer and pending target are left unreset; the state register says when they are live.
  always_ff @(posedge clk) begin
    pend_q       <= pend_d;
    hold_instr_q <= hold_instr_d;
    hold_pc4_q   <= hold_pc4_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_iss_o    <= NOP_INSTR;
      pc_plus4_iss_o <= 32'h0;
      valid_iss_o    <= 1'b0;
    end else if (flush_iss_hz_i) begin
      instr_iss_o <= NOP_INSTR;
      valid_iss_o <= 1'b0;
    end else if (!stall_iss_hz_i) begin
      if (deliver) begin
        instr_iss_o    <= dlv_instr;
        pc_plus4_iss_o <= dlv_pc4;
        valid_iss_o    <= 1'b1;
      end else begin
        instr_iss_o <= NOP_INSTR;
        valid_iss_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_iss_pipe.sv
// Bench for fetch_iss_pipe: directed vectors with literal expectations plus a queue-based
// reference model compared against every output on every cycle.
module tb_fetch_iss_pipe;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_fetch_hz_i, stall_iss_hz_i, flush_iss_hz_i;
  logic        branch_taken_ex_mem_hz_i, jump_iss_ex_hz_i;
  logic [31:0] branch_target_i, jump_target_i;
  logic        imem_req_o, imem_rdy_i;
  logic [31:0] imem_addr_o, imem_data_i;
  logic [31:0] pc_fetch_o, instr_iss_o, pc_plus4_iss_o;
  logic        valid_iss_o;

  fetch_iss_pipe dut (
    .clk                      (clk),
    .reset                    (reset),
    .stall_fetch_hz_i         (stall_fetch_hz_i),
    .stall_iss_hz_i           (stall_iss_hz_i),
    .flush_iss_hz_i           (flush_iss_hz_i),
    .branch_taken_ex_mem_hz_i (branch_taken_ex_mem_hz_i),
    .branch_target_i          (branch_target_i),
    .jump_iss_ex_hz_i         (jump_iss_ex_hz_i),
    .jump_target_i            (jump_target_i),
    .imem_req_o               (imem_req_o),
    .imem_addr_o              (imem_addr_o),
    .imem_rdy_i               (imem_rdy_i),
    .imem_data_i              (imem_data_i),
    .pc_fetch_o               (pc_fetch_o),
    .instr_iss_o              (instr_iss_o),
    .pc_plus4_iss_o           (pc_plus4_iss_o),
    .valid_iss_o              (valid_iss_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'h2000_0001 + (a >> 2);
  endfunction

  // Reference model: fetch PC, an idle countdown after reset, a parked-response queue
  // and a pending-redirect queue; ISSUE contents as plain values.
  typedef struct { logic [31:0] instr; logic [31:0] pc4; } slot_t;
  slot_t       held_q[$];
  logic [31:0] pend_q[$];
  int          boot_left;
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  bit          cmp_on = 1'b0;

  always @(posedge clk) begin
    logic        redir, blocked, give;
    logic [31:0] tgt;
    slot_t       gi;
    give  = 1'b0;
    gi    = '{32'h0, 32'h0};
    redir = branch_taken_ex_mem_hz_i | jump_iss_ex_hz_i;
    tgt   = branch_taken_ex_mem_hz_i ? branch_target_i : jump_target_i;
    blocked = stall_fetch_hz_i | stall_iss_hz_i;
    if (reset) begin
      m_pc = 32'h0; boot_left = 1; held_q.delete(); pend_q.delete();
      m_instr = NOP; m_pc4 = 32'h0; m_valid = 1'b0;
    end else begin
      if (boot_left > 0) begin
        boot_left = 0;
        if (redir) m_pc = tgt;
      end else if (held_q.size() != 0) begin
        if (redir) begin
          held_q.delete(); m_pc = tgt;
        end else if (!blocked && !flush_iss_hz_i) begin
          give = 1'b1; gi = held_q.pop_front(); m_pc = m_pc + 32'd4;
        end
      end else if (pend_q.size() != 0) begin
        if (redir) begin
          pend_q.delete();
          if (imem_rdy_i) m_pc = tgt; else pend_q.push_back(tgt);
        end else if (imem_rdy_i) begin
          m_pc = pend_q.pop_front();
        end
      end else if (redir) begin
        if (imem_rdy_i) m_pc = tgt; else pend_q.push_back(tgt);
      end else if (imem_rdy_i && !flush_iss_hz_i) begin
        if (blocked) held_q.push_back('{imem_data_i, m_pc + 32'd4});
        else begin
          give = 1'b1; gi = '{imem_data_i, m_pc + 32'd4}; m_pc = m_pc + 32'd4;
        end
      end
      if (flush_iss_hz_i) begin
        m_instr = NOP; m_valid = 1'b0;
      end else if (!stall_iss_hz_i) begin
        if (give) begin
          m_instr = gi.instr; m_pc4 = gi.pc4; m_valid = 1'b1;
        end else begin
          m_instr = NOP; m_valid = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      check("model_req",   32'(imem_req_o), 32'((boot_left == 0) && (held_q.size() == 0)));
      check("model_addr",  imem_addr_o, m_pc);
      check("model_pc",    pc_fetch_o, m_pc);
      check("model_instr", instr_iss_o, m_instr);
      check("model_pc4",   pc_plus4_iss_o, m_pc4);
      check("model_valid", 32'(valid_iss_o), 32'(m_valid));
    end
  end

  // Applies one cycle of inputs, waits for the edge, then settles 1 time unit.
  task automatic cyc(input logic rst, input logic rdy, input logic sf, input logic si,
                     input logic fl, input logic bt, input logic [31:0] bt_t,
                     input logic jp, input logic [31:0] jp_t,
                     input logic alt, input logic [31:0] alt_w);
    reset = rst; imem_rdy_i = rdy; stall_fetch_hz_i = sf; stall_iss_hz_i = si;
    flush_iss_hz_i = fl; branch_taken_ex_mem_hz_i = bt; branch_target_i = bt_t;
    jump_iss_ex_hz_i = jp; jump_target_i = jp_t;
    imem_data_i = alt ? alt_w : word_at(imem_addr_o);
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic rdy);
    cyc(1'b0, rdy, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    cmp_on = 1'b1;
    check("rst_req",   32'(imem_req_o), 32'h0);
    check("rst_valid", 32'(valid_iss_o), 32'h0);
    check("rst_instr", instr_iss_o, NOP);
    check("rst_pc4",   pc_plus4_iss_o, 32'h0);
    check("rst_pc",    pc_fetch_o, 32'h0);

    // Boot idle cycle, then back-to-back fetches at 0, 4.
    go(1'b1);
    check("boot_req",  32'(imem_req_o), 32'h1);
    check("boot_addr", imem_addr_o, 32'h0);
    go(1'b1);
    check("f0_instr", instr_iss_o, 32'h2000_0001);
    check("f0_pc4",   pc_plus4_iss_o, 32'h4);
    check("f0_valid", 32'(valid_iss_o), 32'h1);
    go(1'b1);
    check("f1_instr", instr_iss_o, 32'h2000_0002);
    check("f1_pc",    pc_fetch_o, 32'h8);

    // Stall three cycles while pc=8 answers 0xAAAA_0000.
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hAAAA_0000);
    check("hold_req",   32'(imem_req_o), 32'h0);
    check("hold_instr", instr_iss_o, 32'h2000_0002);
    check("hold_valid", 32'(valid_iss_o), 32'h1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h5555_5555);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h5555_5555);
    check("hold_pc", pc_fetch_o, 32'h8);
    go(1'b1);
    check("rel_instr", instr_iss_o, 32'hAAAA_0000);
    check("rel_pc4",   pc_plus4_iss_o, 32'hC);
    check("rel_pc",    pc_fetch_o, 32'hC);
    check("rel_req",   32'(imem_req_o), 32'h1);

    // Branch to 0x100 with flush and a same-cycle jump to 0x200.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
    check("br_addr",  imem_addr_o, 32'h100);
    check("br_valid", 32'(valid_iss_o), 32'h0);
    check("br_instr", instr_iss_o, NOP);
    go(1'b1);
    check("br_tgt_instr", instr_iss_o, 32'h2000_0041);
    check("br_tgt_pc4",   pc_plus4_iss_o, 32'h104);

    // Jump to 0x40 while imem is slow; the stale word must be dropped.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 32'h0);
    check("dr_addr0",  imem_addr_o, 32'h104);
    check("dr_req0",   32'(imem_req_o), 32'h1);
    check("dr_valid0", 32'(valid_iss_o), 32'h0);
    go(1'b0);
    check("dr_addr1", imem_addr_o, 32'h104);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
    check("dr_addr2", imem_addr_o, 32'h40);
    check("dr_valid2", 32'(valid_iss_o), 32'h0);
    check("dr_instr2", instr_iss_o, NOP);
    go(1'b1);
    check("jt_instr", instr_iss_o, 32'h2000_0011);
    check("jt_pc4",   pc_plus4_iss_o, 32'h44);

    // PC wrap at the top of the address space.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0);
    check("wr_pc0", pc_fetch_o, 32'hFFFF_FFFC);
    go(1'b1);
    check("wr_pc1",   pc_fetch_o, 32'h0);
    check("wr_pc4",   pc_plus4_iss_o, 32'h0);
    check("wr_instr", instr_iss_o, 32'h6000_0000);
    check("wr_valid", 32'(valid_iss_o), 32'h1);

    // Reset while a request is outstanding.
    go(1'b1);
    go(1'b0);
    check("mr_req_before", 32'(imem_req_o), 32'h1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("mr_req",   32'(imem_req_o), 32'h0);
    check("mr_valid", 32'(valid_iss_o), 32'h0);
    check("mr_pc",    pc_fetch_o, 32'h0);
    check("mr_instr", instr_iss_o, NOP);

    // Mixed traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 80; i++) begin
      logic rdy, sf, si, bt, jp;
      rdy = ($urandom_range(3) != 0);
      sf  = ($urandom_range(3) == 0);
      si  = sf ? logic'($urandom_range(1)) : ($urandom_range(7) == 0);
      bt  = ($urandom_range(9) == 0);
      jp  = ($urandom_range(9) == 0);
      cyc(1'b0, rdy, sf, si, bt, bt, 32'($urandom_range(63)) << 2,
          jp, 32'($urandom_range(63)) << 2, 1'b0, 32'h0);
    end
    go(1'b1);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
